// File: rtl/irig_frame_tracker_pkg.sv
// rtl/irig_frame_tracker_pkg.sv - shared codes, frame geometry and FSM states for the IRIG-B tracker
package irig_frame_tracker_pkg;

  localparam int         FRAME_LEN = 100;
  localparam logic [6:0] POS_PR    = 7'd0;
  localparam logic [6:0] POS_P0    = 7'd99;

  localparam logic [2:0] TS_NONE    = 3'd0;
  localparam logic [2:0] TS_SEC     = 3'd1;
  localparam logic [2:0] TS_MIN     = 3'd2;
  localparam logic [2:0] TS_HOUR    = 3'd3;
  localparam logic [2:0] TS_DAY     = 3'd4;
  localparam logic [2:0] TS_YEAR    = 3'd5;
  localparam logic [2:0] TS_SEC_DAY = 3'd6;

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_SYNC,
    ST_ACQUIRE,
    ST_LOCKED
  } state_e;

  // Markers sit at Pr (0) and at every position ending in 9 (P1..P9, P0 at 99)
  function automatic logic is_marker_pos(input logic [6:0] pos);
    return (pos == POS_PR) || ((pos % 7'd10) == 7'd9);
  endfunction

endpackage

// File: rtl/irig_frame_tracker_if.sv
// rtl/irig_frame_tracker_if.sv - symbol strobes in, timestamp bit strobes and status out
interface irig_frame_tracker_if;
  logic        irig_d0;
  logic        irig_d1;
  logic        irig_mark;
  logic        pps_gate;
  logic        ts_reset;
  logic        bit_wr;
  logic [2:0]  ts_select;
  logic [1:0]  digit_idx;
  logic [4:0]  bit_idx;
  logic        bit_value;
  logic        locked;
  logic        frame_done;
  logic [15:0] err_cnt;

  modport master (
    output irig_d0, irig_d1, irig_mark,
    input  pps_gate, ts_reset, bit_wr, ts_select, digit_idx, bit_idx, bit_value,
    input  locked, frame_done, err_cnt
  );

  modport slave (
    input  irig_d0, irig_d1, irig_mark,
    output pps_gate, ts_reset, bit_wr, ts_select, digit_idx, bit_idx, bit_value,
    output locked, frame_done, err_cnt
  );
endinterface

// File: rtl/irig_frame_tracker_pos_decode.sv
// rtl/irig_frame_tracker_pos_decode.sv - frame position to timestamp field/digit/bit slot
module irig_pos_decode
  import irig_frame_tracker_pkg::*;
#(
  parameter bit SBS_EN  = 1'b1,
  parameter bit YEAR_EN = 1'b1
) (
  input  logic [6:0] pos,
  output logic       valid,
  output logic [2:0] ts_select,
  output logic [1:0] digit_idx,
  output logic [4:0] bit_idx
);

  // Map each data position to its field slot; index bits and unused spans stay invalid
  always_comb begin
    valid     = 1'b1;
    ts_select = TS_NONE;
    digit_idx = 2'd0;
    bit_idx   = 5'd0;
    if (pos >= 7'd1 && pos <= 7'd4) begin
      ts_select = TS_SEC;  bit_idx = 5'(pos - 7'd1);
    end else if (pos >= 7'd6 && pos <= 7'd8) begin
      ts_select = TS_SEC;  digit_idx = 2'd1; bit_idx = 5'(pos - 7'd6);
    end else if (pos >= 7'd10 && pos <= 7'd13) begin
      ts_select = TS_MIN;  bit_idx = 5'(pos - 7'd10);
    end else if (pos >= 7'd15 && pos <= 7'd17) begin
      ts_select = TS_MIN;  digit_idx = 2'd1; bit_idx = 5'(pos - 7'd15);
    end else if (pos >= 7'd20 && pos <= 7'd23) begin
      ts_select = TS_HOUR; bit_idx = 5'(pos - 7'd20);
    end else if (pos >= 7'd25 && pos <= 7'd26) begin
      ts_select = TS_HOUR; digit_idx = 2'd1; bit_idx = 5'(pos - 7'd25);
    end else if (pos >= 7'd30 && pos <= 7'd33) begin
      ts_select = TS_DAY;  bit_idx = 5'(pos - 7'd30);
    end else if (pos >= 7'd35 && pos <= 7'd38) begin
      ts_select = TS_DAY;  digit_idx = 2'd1; bit_idx = 5'(pos - 7'd35);
    end else if (pos >= 7'd40 && pos <= 7'd41) begin
      ts_select = TS_DAY;  digit_idx = 2'd2; bit_idx = 5'(pos - 7'd40);
    end else if (YEAR_EN && pos >= 7'd50 && pos <= 7'd53) begin
      ts_select = TS_YEAR; bit_idx = 5'(pos - 7'd50);
    end else if (YEAR_EN && pos >= 7'd55 && pos <= 7'd58) begin
      ts_select = TS_YEAR; digit_idx = 2'd1; bit_idx = 5'(pos - 7'd55);
    end else if (SBS_EN && pos >= 7'd80 && pos <= 7'd88) begin
      ts_select = TS_SEC_DAY; bit_idx = 5'(pos - 7'd80);
    end else if (SBS_EN && pos >= 7'd90 && pos <= 7'd97) begin
      // P9 at 89 splits the SBS word, so the upper bits resume at bit 9
      ts_select = TS_SEC_DAY; bit_idx = 5'(pos - 7'd81);
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/irig_frame_tracker.sv
// rtl/irig_frame_tracker.sv - IRIG-B frame position tracker with lock hysteresis and bit strobes
module irig_frame_tracker
  import irig_frame_tracker_pkg::*;
#(
  parameter int LOCK_FRAMES = 2,
  parameter int MAX_ERR     = 3,
  parameter bit SBS_EN      = 1'b1,
  parameter bit YEAR_EN     = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  irig_frame_tracker_if.slave bus
);

  state_e      state_q, state_d;
  logic [6:0]  pos_q, pos_d;
  logic [7:0]  good_q, good_d, err_run_q, err_run_d;
  logic        frame_err_q, frame_err_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        pps_gate_q, pps_gate_d, ts_reset_q, ts_reset_d;
  logic        bit_wr_q, bit_wr_d, bit_value_q, bit_value_d;
  logic [2:0]  ts_select_q, ts_select_d;
  logic [1:0]  digit_idx_q, digit_idx_d;
  logic [4:0]  bit_idx_q, bit_idx_d;
  logic        locked_q, locked_d, frame_done_q, frame_done_d;

  logic        symbol, multi, is_mark, is_data, sym_err, frame_bad;
  logic [7:0]  good_inc, err_inc;
  logic        dec_valid;
  logic [2:0]  dec_sel;
  logic [1:0]  dec_digit;
  logic [4:0]  dec_bit;

  irig_pos_decode #(.SBS_EN(SBS_EN), .YEAR_EN(YEAR_EN)) u_pos_decode (
    .pos       (pos_q),
    .valid     (dec_valid),
    .ts_select (dec_sel),
    .digit_idx (dec_digit),
    .bit_idx   (dec_bit)
  );

  assign symbol  = bus.irig_d0 | bus.irig_d1 | bus.irig_mark;
  assign multi   = (bus.irig_d0 & bus.irig_d1) | (bus.irig_d0 & bus.irig_mark) |
                   (bus.irig_d1 & bus.irig_mark);
  assign is_mark = bus.irig_mark & ~multi;
  assign is_data = (bus.irig_d0 | bus.irig_d1) & ~multi;
  assign sym_err = multi | (is_mark & ~is_marker_pos(pos_q)) | (is_data & is_marker_pos(pos_q));

  // Next-state: lock FSM, flywheel position, frame error bookkeeping and output strobes
  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    good_d       = good_q;
    err_run_d    = err_run_q;
    frame_err_d  = frame_err_q;
    err_cnt_d    = err_cnt_q;
    pps_gate_d   = 1'b0;
    ts_reset_d   = 1'b0;
    bit_wr_d     = 1'b0;
    ts_select_d  = TS_NONE;
    digit_idx_d  = 2'd0;
    bit_idx_d    = 5'd0;
    bit_value_d  = 1'b0;
    frame_done_d = 1'b0;
    frame_bad    = frame_err_q | sym_err;
    good_inc     = good_q + 8'd1;
    err_inc      = err_run_q + 8'd1;
    if (symbol) begin
      case (state_q)
        ST_UNLOCKED: if (is_mark) state_d = ST_SYNC;
        ST_SYNC: begin
          if (is_mark) begin
            // Second consecutive mark is Pr: frame position 0 just went by
            state_d     = ST_ACQUIRE;
            pos_d       = 7'd1;
            ts_reset_d  = 1'b1;
            good_d      = 8'd0;
            frame_err_d = 1'b0;
          end else begin
            state_d = ST_UNLOCKED;
          end
        end
        default: begin
          pos_d       = (pos_q == POS_P0) ? POS_PR : pos_q + 7'd1;
          frame_err_d = frame_bad;
          if (sym_err && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          if (is_data && dec_valid) begin
            bit_wr_d    = 1'b1;
            ts_select_d = dec_sel;
            digit_idx_d = dec_digit;
            bit_idx_d   = dec_bit;
            bit_value_d = bus.irig_d1;
          end
          if (is_mark && pos_q == POS_PR) begin
            ts_reset_d = 1'b1;
            pps_gate_d = (state_q == ST_LOCKED);
          end
          if (state_q == ST_ACQUIRE && sym_err) begin
            state_d = ST_UNLOCKED;
          end else if (pos_q == POS_P0) begin
            frame_err_d = 1'b0;
            if (!frame_bad) begin
              frame_done_d = 1'b1;
              err_run_d    = 8'd0;
              if (state_q == ST_ACQUIRE) begin
                good_d = good_inc;
                if (good_inc == 8'(LOCK_FRAMES)) state_d = ST_LOCKED;
              end
            end else begin
              err_run_d = err_inc;
              if (err_inc == 8'(MAX_ERR)) state_d = ST_UNLOCKED;
            end
          end
        end
      endcase
    end
    if (state_d == ST_UNLOCKED) begin
      good_d      = 8'd0;
      err_run_d   = 8'd0;
      frame_err_d = 1'b0;
      pos_d       = POS_PR;
    end
    locked_d = (state_d == ST_LOCKED);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_UNLOCKED;
      pos_q        <= POS_PR;
      good_q       <= 8'd0;
      err_run_q    <= 8'd0;
      frame_err_q  <= 1'b0;
      err_cnt_q    <= 16'd0;
      pps_gate_q   <= 1'b0;
      ts_reset_q   <= 1'b0;
      bit_wr_q     <= 1'b0;
      ts_select_q  <= TS_NONE;
      digit_idx_q  <= 2'd0;
      bit_idx_q    <= 5'd0;
      bit_value_q  <= 1'b0;
      locked_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      good_q       <= good_d;
      err_run_q    <= err_run_d;
      frame_err_q  <= frame_err_d;
      err_cnt_q    <= err_cnt_d;
      pps_gate_q   <= pps_gate_d;
      ts_reset_q   <= ts_reset_d;
      bit_wr_q     <= bit_wr_d;
      ts_select_q  <= ts_select_d;
      digit_idx_q  <= digit_idx_d;
      bit_idx_q    <= bit_idx_d;
      bit_value_q  <= bit_value_d;
      locked_q     <= locked_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.pps_gate   = pps_gate_q;
  assign bus.ts_reset   = ts_reset_q;
  assign bus.bit_wr     = bit_wr_q;
  assign bus.ts_select  = ts_select_q;
  assign bus.digit_idx  = digit_idx_q;
  assign bus.bit_idx    = bit_idx_q;
  assign bus.bit_value  = bit_value_q;
  assign bus.locked     = locked_q;
  assign bus.frame_done = frame_done_q;
  assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_irig_frame_tracker.sv
// tb/tb_irig_frame_tracker.sv - scoreboard bench for irig_frame_tracker
module tb_irig_frame_tracker;

  typedef struct packed {
    logic        pps;
    logic        tsr;
    logic        bw;
    logic [2:0]  sel;
    logic [1:0]  dig;
    logic [4:0]  bidx;
    logic        bval;
    logic        locked;
    logic        fdone;
    logic [15:0] errcnt;
  } exp_t;

  localparam int LOCK_FRAMES = 2;
  localparam int MAX_ERR     = 3;
  localparam int M_UNL = 0, M_SYNC = 1, M_ACQ = 2, M_LOCK = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  irig_frame_tracker_if bus ();
  irig_frame_tracker_if bus2 ();

  assign bus2.irig_d0   = bus.irig_d0;
  assign bus2.irig_d1   = bus.irig_d1;
  assign bus2.irig_mark = bus.irig_mark;

  irig_frame_tracker #(.LOCK_FRAMES(LOCK_FRAMES), .MAX_ERR(MAX_ERR), .SBS_EN(1'b1), .YEAR_EN(1'b1))
    dut (.clk(clk), .rst(rst), .bus(bus));

  irig_frame_tracker #(.LOCK_FRAMES(LOCK_FRAMES), .MAX_ERR(MAX_ERR), .SBS_EN(1'b0), .YEAR_EN(1'b0))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t exp_q[$];

  // Field layout: select code, digit, first position, bit count, first bit index
  int r_sel   [13] = '{1, 1, 2, 2, 3, 3, 4, 4, 4, 5, 5, 6, 6};
  int r_dig   [13] = '{0, 1, 0, 1, 0, 1, 0, 1, 2, 0, 1, 0, 0};
  int r_start [13] = '{1, 6, 10, 15, 20, 25, 30, 35, 40, 50, 55, 80, 90};
  int r_n     [13] = '{4, 3, 4, 3, 4, 2, 4, 4, 2, 4, 4, 9, 8};
  int r_b0    [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9};
  int tsel [100];
  int tdig [100];
  int tbit [100];
  logic [2:0] frm [100];

  int m_mode, m_pos, m_good, m_errrun, m_errcnt, m_bw_core;
  bit m_fbad;

  int n2_bw = 0, n2_opt = 0, n_sbs = 0;

  always @(negedge clk) begin
    if (bus2.bit_wr) begin
      n2_bw++;
      if (bus2.ts_select == 3'd5 || bus2.ts_select == 3'd6) n2_opt++;
    end
    if (bus.bit_wr && bus.ts_select == 3'd6) n_sbs++;
  end

  function automatic bit marker_at(input int p);
    return (p == 0) || (p % 10 == 9);
  endfunction

  function automatic void build_table();
    for (int p = 0; p < 100; p++) begin tsel[p] = 0; tdig[p] = 0; tbit[p] = 0; end
    for (int k = 0; k < 13; k++)
      for (int j = 0; j < r_n[k]; j++) begin
        tsel[r_start[k] + j] = r_sel[k];
        tdig[r_start[k] + j] = r_dig[k];
        tbit[r_start[k] + j] = r_b0[k] + j;
      end
  endfunction

  function automatic void build_frame(input int sec, input int mn, input int hr, input int day,
                                      input int yr, input int sbs);
    int vals[7];
    int dv, b, p;
    vals = '{0, sec, mn, hr, day, yr, sbs};
    for (int q = 0; q < 100; q++) frm[q] = marker_at(q) ? 3'b100 : 3'b001;
    for (int k = 0; k < 13; k++)
      for (int j = 0; j < r_n[k]; j++) begin
        p = r_start[k] + j;
        if (r_sel[k] == 6) b = (sbs >> (r_b0[k] + j)) & 1;
        else begin
          dv = vals[r_sel[k]];
          for (int d = 0; d < r_dig[k]; d++) dv = dv / 10;
          b = ((dv % 10) >> j) & 1;
        end
        frm[p] = (b != 0) ? 3'b010 : 3'b001;
      end
  endfunction

  function automatic void model_reset();
    m_mode = M_UNL; m_pos = 0; m_good = 0; m_errrun = 0; m_errcnt = 0; m_fbad = 0;
  endfunction

  // Reference behaviour for one received symbol s = {mark, d1, d0}
  function automatic exp_t model_sym(input logic [2:0] s);
    exp_t e;
    int   n;
    bit   mk, dat, bad;
    e   = '0;
    n   = int'(s[0]) + int'(s[1]) + int'(s[2]);
    mk  = (s == 3'b100);
    dat = (n == 1) && !s[2];
    bad = (n > 1) || (mk && !marker_at(m_pos)) || (dat && marker_at(m_pos));
    if (m_mode == M_UNL) begin
      if (mk) m_mode = M_SYNC;
    end else if (m_mode == M_SYNC) begin
      if (mk) begin
        m_mode = M_ACQ; m_pos = 1; e.tsr = 1'b1; m_good = 0; m_fbad = 0;
      end else m_mode = M_UNL;
    end else begin
      if (bad && m_errcnt < 65535) m_errcnt++;
      if (dat && tsel[m_pos] != 0) begin
        e.bw = 1'b1; e.sel = 3'(tsel[m_pos]); e.dig = 2'(tdig[m_pos]);
        e.bidx = 5'(tbit[m_pos]); e.bval = s[1];
        if (tsel[m_pos] <= 4) m_bw_core++;
      end
      if (m_pos == 0 && mk) begin e.tsr = 1'b1; e.pps = (m_mode == M_LOCK); end
      m_fbad = m_fbad | bad;
      if (m_mode == M_ACQ && bad) m_mode = M_UNL;
      else if (m_pos == 99) begin
        if (!m_fbad) begin
          e.fdone = 1'b1; m_errrun = 0; m_good++;
          if (m_mode == M_ACQ && m_good == LOCK_FRAMES) m_mode = M_LOCK;
        end else begin
          m_errrun++;
          if (m_errrun == MAX_ERR) m_mode = M_UNL;
        end
        m_fbad = 0;
      end
      m_pos = (m_pos + 1) % 100;
    end
    if (m_mode == M_UNL) begin m_good = 0; m_errrun = 0; m_fbad = 0; m_pos = 0; end
    e.locked = (m_mode == M_LOCK);
    e.errcnt = 16'(m_errcnt);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic send_sym(input logic [2:0] s);
    bus.irig_d0   = s[0];
    bus.irig_d1   = s[1];
    bus.irig_mark = s[2];
    exp_q.push_back(model_sym(s));
    @(posedge clk); #1;
    bus.irig_d0 = 1'b0; bus.irig_d1 = 1'b0; bus.irig_mark = 1'b0;
    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
  endtask

  // ek 0: wrong symbol class at ep, ek 1: d0+mark together at ep
  task automatic send_frame(input int ep, input int ek, input int n_syms = 100);
    logic [2:0] s;
    for (int p = 0; p < n_syms; p++) begin
      s = frm[p];
      if (p == ep) s = (ek == 1) ? 3'b101 : (marker_at(p) ? 3'b010 : 3'b100);
      send_sym(s);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    bus.irig_d0 = 1'b0; bus.irig_d1 = 1'b0; bus.irig_mark = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {bus.pps_gate, bus.ts_reset, bus.bit_wr, bus.ts_select, bus.digit_idx,
                            bus.bit_idx, bus.bit_value, bus.locked, bus.frame_done, bus.err_cnt}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic relock(input int sec, input int mn, input int hr, input int day, input int yr);
    build_frame(sec, mn, hr, day, yr, hr * 3600 + mn * 60 + sec);
    if (m_mode == M_UNL) send_sym(3'b100);
    send_frame(-1, 0);
    send_frame(-1, 0);
  endtask

  // Monitor: each cycle after a symbol pops one expectation; other cycles must be quiet
  initial begin : monitor
    bit   had;
    exp_t a, e;
    forever begin
      @(posedge clk);
      had = bus.irig_d0 | bus.irig_d1 | bus.irig_mark;
      @(negedge clk);
      a = {bus.pps_gate, bus.ts_reset, bus.bit_wr, bus.ts_select, bus.digit_idx, bus.bit_idx,
           bus.bit_value, bus.locked, bus.frame_done, bus.err_cnt};
      n_tests++;
      if (had) begin
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sym_underflow: got %0h, expected no output", a);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            n_fail++;
            $display("FAIL sym_response: got %0h, expected %0h", a, e);
          end
        end
      end else if ({a.pps, a.tsr, a.bw, a.fdone, a.sel} != 7'd0) begin
        n_fail++;
        $display("FAIL idle_quiet: got %0h, expected pulses 0", {a.pps, a.tsr, a.bw, a.fdone, a.sel});
      end
    end
  end

  initial begin : stim
    int ep, sb0;
    m_bw_core = 0;
    build_table();
    model_reset();
    bus.irig_d0 = 1'b0; bus.irig_d1 = 1'b0; bus.irig_mark = 1'b0;
    @(posedge clk); #1;
    do_reset();

    repeat (20) send_sym(($urandom_range(0, 1) == 0) ? 3'b001 : 3'b010);
    send_sym(3'b001);
    check("unlocked_before_sync", 32'(bus.locked), 32'd0);

    relock(37, 59, 12, 366, 24);
    drain();
    check("locked_after_two_frames", 32'(bus.locked), 32'd1);
    build_frame(37, 59, 23, 366, 25, 86399);
    send_frame(-1, 0);

    send_frame(45, 0);
    send_frame(45, 0);
    drain();
    check("locked_after_two_bad", 32'(bus.locked), 32'd1);
    check("err_cnt_two_bad", 32'(bus.err_cnt), 32'd2);
    send_frame(45, 0);
    drain();
    check("unlocked_after_three_bad", 32'(bus.locked), 32'd0);
    check("err_cnt_three_bad", 32'(bus.err_cnt), 32'd3);

    send_sym(3'b100);
    send_frame(19, 0);
    drain();
    check("acquire_error_unlocked", 32'(bus.locked), 32'd0);
    check("err_cnt_acquire", 32'(bus.err_cnt), 32'd4);

    relock(5, 30, 8, 123, 99);
    send_frame(12, 1);
    drain();
    check("locked_after_multi", 32'(bus.locked), 32'd1);
    check("err_cnt_multi", 32'(bus.err_cnt), 32'd5);

    build_frame(59, 59, 23, 365, 99, 86399);
    sb0 = n_sbs;
    send_frame(-1, 0);
    drain();
    check("sbs_strobe_count", 32'(n_sbs - sb0), 32'd17);

    repeat (12) begin
      build_frame($urandom_range(0, 59), $urandom_range(0, 59), $urandom_range(0, 23),
                  $urandom_range(1, 366), $urandom_range(0, 99), $urandom_range(0, 86399));
      ep = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 99) : -1;
      if (m_mode == M_UNL) send_sym(3'b100);
      send_frame(ep, $urandom_range(0, 1));
    end

    relock(11, 22, 13, 200, 7);
    build_frame(1, 2, 3, 4, 5, 6);
    send_frame(-1, 0, 50);
    drain();
    check("locked_before_midreset", 32'(bus.locked), 32'd1);
    do_reset();

    check("no_opt_strobes_when_disabled", 32'(n2_opt), 32'd0);
    check("core_strobes_when_disabled", 32'(n2_bw), 32'(m_bw_core));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
